mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one requester at a time exclusive use of the shared
// packet/table memory port. A grant is held for the whole burst (no
// preemption) and is handed to a waiting requester without an idle bubble.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin winner selection;
// without it the lowest requester index wins and last_owner is not built.

`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef ZERO_ADDR
`define ZERO_ADDR 32'h0000_0000
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif

module mem_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_ce_i,
  input  logic [NUM_REQ-1:0]              req_we_i,
  input  logic [NUM_REQ-1:0][`ADDR_BUS]   req_addr_i,
  input  logic [NUM_REQ-1:0][3:0]         req_width_i,
  input  logic [NUM_REQ-1:0][`DATA_BUS]   req_data_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [`DATA_BUS]                req_data_o,
  output logic                            mem_ce_o,
  output logic                            mem_we_o,
  output logic [`ADDR_BUS]                mem_addr_o,
  output logic [3:0]                      mem_width_o,
  output logic [`DATA_BUS]                mem_data_o,
  input  logic [`DATA_BUS]                mem_data_i,
  output logic                            busy_o,
  output logic [1:0]                      owner_o
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  arb_state_t         state_reg;
  logic [OW-1:0]      owner_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic               busy_reg;

  // Requesters eligible to win this cycle: the current (or just-released)
  // owner is excluded, so an owner re-raising ce right after release has to
  // wait a cycle and cannot immediately recapture the port.
  logic [NUM_REQ-1:0] cand;
  // One-hot form of the selected winner index.
  logic [NUM_REQ-1:0] win_onehot;
  logic [OW-1:0]      win_idx;
  logic               win_valid;
  // Owner still holding its request; low means the burst ends this cycle.
  logic               owner_ce;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign cand[gi]       = req_ce_i[gi] & ~gnt_reg[gi];
      assign win_onehot[gi] = win_valid && (win_idx == OW'(gi));
    end
  endgenerate

  assign owner_ce  = |(req_ce_i & gnt_reg);
  assign win_valid = |cand;

`ifdef ARB_ROUND_ROBIN_EN
  logic [OW-1:0] last_owner_reg;
  logic [OW-1:0] rr_base;

  // Round-robin pick: search starts just after the most recent owner. During
  // a handover the outgoing owner becomes that reference point immediately.
  always_comb begin
    rr_base = (state_reg == ARB_BUSY) ? owner_reg : last_owner_reg;
    win_idx = '0;
    // Walk farthest-to-nearest so the nearest candidate is assigned last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (cand[(int'(rr_base) + k) % NUM_REQ]) begin
        win_idx = OW'((int'(rr_base) + k) % NUM_REQ);
      end
    end
  end
`else
  // Fixed priority pick: the lowest requester index wins.
  always_comb begin
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand[k]) begin
        win_idx = OW'(k);
      end
    end
  end
`endif

  // Arbitration FSM: owner, grant and busy are all registered here.
  always_ff @(posedge clk) begin
    if (rst == `TRUE) begin
      state_reg <= ARB_IDLE;
      owner_reg <= '0;
      gnt_reg   <= '0;
      busy_reg  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_reg <= OW'(NUM_REQ - 1);
`endif
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (win_valid) begin
            state_reg <= ARB_BUSY;
            owner_reg <= win_idx;
            gnt_reg   <= win_onehot;
            busy_reg  <= 1'b1;
          end
        end
        ARB_BUSY: begin
          // Burst lock: nothing changes while the owner keeps ce high.
          if (!owner_ce) begin
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_reg <= owner_reg;
`endif
            if (win_valid) begin
              // Zero-bubble handover straight to the next winner.
              owner_reg <= win_idx;
              gnt_reg   <= win_onehot;
            end else begin
              state_reg <= ARB_IDLE;
              owner_reg <= '0;
              gnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= ARB_IDLE;
          owner_reg <= '0;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Memory command mux: only the granted requester with ce high reaches the
  // memory; every other case drives an all-zero idle command.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = `ZERO_ADDR;
    mem_width_o = 4'd0;
    mem_data_o  = `ZERO_WORD;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_reg[k] && req_ce_i[k]) begin
        mem_ce_o    = 1'b1;
        mem_we_o    = req_we_i[k];
        mem_addr_o  = req_addr_i[k];
        mem_width_o = req_width_i[k];
        mem_data_o  = req_data_i[k];
      end
    end
  end

  assign gnt_o      = gnt_reg;
  assign busy_o     = busy_reg;
  assign owner_o    = 2'(owner_reg);
  assign req_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven check of the memory arbiter plus hand-written
// sequences for reset mid-burst and simultaneous requests from reset.
// Expectations follow the fixed-priority build unless ARB_ROUND_ROBIN_EN is
// defined for the compile.

module tb_mem_arbiter;

  localparam int N = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_ce;
  logic [N-1:0]         req_we;
  logic [N-1:0][31:0]   req_addr;
  logic [N-1:0][3:0]    req_width;
  logic [N-1:0][31:0]   req_data;
  logic [N-1:0]         gnt;
  logic [31:0]          rd_data;
  logic                 mem_ce;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [3:0]           mem_width;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;
  logic                 busy;
  logic [1:0]           owner;

  int total = 0;
  int bad   = 0;

  // Fixed per-requester command fields (requester 0 is the 0x80 write case).
  logic [31:0] addr_k  [N] = '{32'h0000_0080, 32'h0000_1104, 32'h0000_2208};
  logic [31:0] data_k  [N] = '{32'hDEAD_BEEF, 32'h1111_2222, 32'h3333_4444};
  logic [3:0]  width_k [N] = '{4'd4, 4'd2, 4'd1};

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_ce_i   (req_ce),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_width_i(req_width),
    .req_data_i (req_data),
    .gnt_o      (gnt),
    .req_data_o (rd_data),
    .mem_ce_o   (mem_ce),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_width_o(mem_width),
    .mem_data_o (mem_wdata),
    .mem_data_i (mem_rdata),
    .busy_o     (busy),
    .owner_o    (owner)
  );

  typedef struct {
    logic [2:0] ce;
    logic [2:0] we;
    logic [2:0] gnt;
    logic       busy;
    logic [1:0] owner;
    int         src;   // requester expected on the memory port, -1 = none
    logic       mwe;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic drive(input logic r, input logic [2:0] ce, input logic [2:0] we);
    @(posedge clk);
    #1;
    rst    = r;
    req_ce = ce;
    req_we = we;
  endtask

  // Compare all outputs at the falling edge of the current cycle.
  task automatic expect_out(input string tag, input logic [2:0] g, input logic b,
                            input logic [1:0] o, input int src, input logic w);
    @(negedge clk);
    $display("%s: ce=%b we=%b gnt=%b busy=%b owner=%0d mem_ce=%b mem_we=%b addr=%h",
             tag, req_ce, req_we, gnt, busy, owner, mem_ce, mem_we, mem_addr);
    chk({tag, ".gnt"},   32'(gnt),   32'(g));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".owner"}, 32'(owner), 32'(o));
    chk({tag, ".ce"},    32'(mem_ce), (src >= 0) ? 32'd1 : 32'd0);
    chk({tag, ".we"},    32'(mem_we), 32'(w));
    chk({tag, ".addr"},  mem_addr,   (src >= 0) ? addr_k[src] : 32'h0);
    chk({tag, ".width"}, 32'(mem_width), (src >= 0) ? 32'(width_k[src]) : 32'h0);
    chk({tag, ".wdata"}, mem_wdata,  (src >= 0) ? data_k[src] : 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_ce    = '0;
    req_we    = '0;
    mem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < N; k++) begin
      req_addr[k]  = addr_k[k];
      req_width[k] = width_k[k];
      req_data[k]  = data_k[k];
    end

    //            ce      we      gnt     busy  own   src mwe
    vecs[0]  = '{3'b010, 3'b000, 3'b000, 1'b0, 2'd0, -1, 1'b0};
    vecs[1]  = '{3'b010, 3'b000, 3'b010, 1'b1, 2'd1,  1, 1'b0};
    vecs[2]  = '{3'b010, 3'b000, 3'b010, 1'b1, 2'd1,  1, 1'b0};
    vecs[3]  = '{3'b010, 3'b000, 3'b010, 1'b1, 2'd1,  1, 1'b0};
    vecs[4]  = '{3'b000, 3'b000, 3'b010, 1'b1, 2'd1, -1, 1'b0};
    vecs[5]  = '{3'b000, 3'b000, 3'b000, 1'b0, 2'd0, -1, 1'b0};
    vecs[6]  = '{3'b001, 3'b001, 3'b000, 1'b0, 2'd0, -1, 1'b0};
    vecs[7]  = '{3'b101, 3'b001, 3'b001, 1'b1, 2'd0,  0, 1'b1};
    vecs[8]  = '{3'b100, 3'b000, 3'b001, 1'b1, 2'd0, -1, 1'b0};
    vecs[9]  = '{3'b100, 3'b000, 3'b100, 1'b1, 2'd2,  2, 1'b0};
    vecs[10] = '{3'b000, 3'b000, 3'b100, 1'b1, 2'd2, -1, 1'b0};
    vecs[11] = '{3'b010, 3'b000, 3'b000, 1'b0, 2'd0, -1, 1'b0};
    vecs[12] = '{3'b011, 3'b000, 3'b010, 1'b1, 2'd1,  1, 1'b0};
    vecs[13] = '{3'b111, 3'b100, 3'b010, 1'b1, 2'd1,  1, 1'b0};
    vecs[14] = '{3'b101, 3'b100, 3'b010, 1'b1, 2'd1, -1, 1'b0};
`ifdef ARB_ROUND_ROBIN_EN
    vecs[15] = '{3'b101, 3'b100, 3'b100, 1'b1, 2'd2,  2, 1'b1};
    vecs[16] = '{3'b000, 3'b000, 3'b100, 1'b1, 2'd2, -1, 1'b0};
`else
    vecs[15] = '{3'b101, 3'b100, 3'b001, 1'b1, 2'd0,  0, 1'b0};
    vecs[16] = '{3'b000, 3'b000, 3'b001, 1'b1, 2'd0, -1, 1'b0};
`endif
    vecs[17] = '{3'b000, 3'b000, 3'b000, 1'b0, 2'd0, -1, 1'b0};

    // Reset dominates simultaneous requests.
    drive(1'b1, 3'b111, 3'b111);
    drive(1'b1, 3'b000, 3'b000);
    expect_out("reset", 3'b000, 1'b0, 2'd0, -1, 1'b0);
    chk("rd_data", rd_data, 32'hCAFE_F00D);

    for (int i = 0; i < 18; i++) begin
      drive(1'b0, vecs[i].ce, vecs[i].we);
      expect_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy,
                 vecs[i].owner, vecs[i].src, vecs[i].mwe);
    end

    // Reset in the middle of a requester-2 write burst.
    drive(1'b0, 3'b100, 3'b100);
    expect_out("rstmid0", 3'b000, 1'b0, 2'd0, -1, 1'b0);
    drive(1'b0, 3'b100, 3'b100);
    expect_out("rstmid1", 3'b100, 1'b1, 2'd2, 2, 1'b1);
    drive(1'b1, 3'b100, 3'b100);
    expect_out("rstmid2", 3'b100, 1'b1, 2'd2, 2, 1'b1);
    drive(1'b0, 3'b100, 3'b100);
    expect_out("rstmid3", 3'b000, 1'b0, 2'd0, -1, 1'b0);
    drive(1'b0, 3'b100, 3'b100);
    expect_out("rstmid4", 3'b100, 1'b1, 2'd2, 2, 1'b1);

    // All three request straight out of reset.
    drive(1'b1, 3'b111, 3'b000);
    drive(1'b0, 3'b111, 3'b000);
    expect_out("sim0", 3'b000, 1'b0, 2'd0, -1, 1'b0);
    drive(1'b0, 3'b110, 3'b000);
    expect_out("sim1", 3'b001, 1'b1, 2'd0, -1, 1'b0);
    drive(1'b0, 3'b101, 3'b000);
    expect_out("sim2", 3'b010, 1'b1, 2'd1, -1, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
    drive(1'b0, 3'b011, 3'b000);
    expect_out("sim3", 3'b100, 1'b1, 2'd2, -1, 1'b0);
    drive(1'b0, 3'b101, 3'b000);
    expect_out("sim4", 3'b001, 1'b1, 2'd0, 0, 1'b0);
`else
    drive(1'b0, 3'b110, 3'b000);
    expect_out("sim3", 3'b001, 1'b1, 2'd0, -1, 1'b0);
    drive(1'b0, 3'b101, 3'b000);
    expect_out("sim4", 3'b010, 1'b1, 2'd1, -1, 1'b0);
`endif
    drive(1'b0, 3'b101, 3'b000);
    expect_out("sim5", 3'b001, 1'b1, 2'd0, 0, 1'b0);
    drive(1'b0, 3'b000, 3'b000);
    expect_out("sim6", 3'b001, 1'b1, 2'd0, -1, 1'b0);
    drive(1'b0, 3'b000, 3'b000);
    expect_out("sim7", 3'b000, 1'b0, 2'd0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
